// File: rtl/fpu_dram_arbiter.sv
// Arbiter for the single FPU DRAM port. Two burst requesters share it:
// the read-fill channel and the write-drain channel. Grants are
// round-robin and stay locked until a full burst has transferred.
module fpu_dram_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned BURST_LEN  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_grant,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_valid,
  output logic                  rd_done,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_grant,
  output logic                  wr_beat,
  output logic                  wr_done,
  output logic                  fpu_ready,
  input  logic                  dram_ready,
  output logic                  dram_write,
  output logic [ADDR_WIDTH-1:0] dram_addr,
  output logic [DATA_WIDTH-1:0] dram_wr_data,
  input  logic [DATA_WIDTH-1:0] dram_rd_data
);

  localparam int unsigned CntWidth = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [ADDR_WIDTH-1:0] BeatBytes = ADDR_WIDTH'(DATA_WIDTH / 8);
  localparam logic [CntWidth-1:0] LastBeat = CntWidth'(BURST_LEN - 1);

  typedef enum logic [1:0] {StIdle, StBurst, StDone} state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;           // 1: write channel owns the port
  logic                  last_owner_q, last_owner_d; // owner of the previous burst
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [CntWidth-1:0]   beat_cnt_q, beat_cnt_d;

  // State register; last_owner resets to write so read wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      base_q       <= '0;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      base_q       <= base_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  // Next state: arbitrate in idle, count beats in burst, record owner on done
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    base_d       = base_q;
    beat_cnt_d   = beat_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (rd_req || wr_req) begin
          // On a tie the channel that did not own the last burst wins
          owner_d    = (rd_req && wr_req) ? ~last_owner_q : wr_req;
          base_d     = owner_d ? wr_addr : rd_addr;
          beat_cnt_d = '0;
          state_d    = StBurst;
        end
      end
      StBurst: begin
        if (dram_ready) begin
          if (beat_cnt_q == LastBeat) begin
            state_d = StDone;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      StDone: begin
        last_owner_d = owner_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: decoded from state; read data and beat strobes pass through combinationally
  always_comb begin
    rd_grant      = 1'b0;
    wr_grant      = 1'b0;
    rd_data       = '0;
    rd_data_valid = 1'b0;
    rd_done       = 1'b0;
    wr_beat       = 1'b0;
    wr_done       = 1'b0;
    fpu_ready     = 1'b0;
    dram_write    = 1'b0;
    dram_addr     = '0;
    dram_wr_data  = '0;
    unique case (state_q)
      StBurst: begin
        rd_grant      = ~owner_q;
        wr_grant      = owner_q;
        fpu_ready     = 1'b1;
        dram_write    = owner_q;
        dram_addr     = base_q + ADDR_WIDTH'(beat_cnt_q) * BeatBytes;
        rd_data_valid = dram_ready & ~owner_q;
        rd_data       = rd_data_valid ? dram_rd_data : '0;
        wr_beat       = dram_ready & owner_q;
        dram_wr_data  = owner_q ? wr_data : '0;
      end
      StDone: begin
        rd_done = ~owner_q;
        wr_done = owner_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fpu_dram_arbiter.sv
// Randomised bench for fpu_dram_arbiter with a transaction-level model,
// plus a BURST_LEN=1 instance exercised by directed stimulus.
module tb_fpu_dram_arbiter;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int BL = 8;

  logic          clk, rst_n;
  logic          rd_req, wr_req, dram_ready;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] wr_data, dram_rd_data;
  logic          rd_grant, rd_data_valid, rd_done, wr_grant, wr_beat, wr_done;
  logic          fpu_ready, dram_write;
  logic [DW-1:0] rd_data, dram_wr_data;
  logic [AW-1:0] dram_addr;

  // BURST_LEN=1 instance signals
  logic          rd_req1, dram_ready1;
  logic [AW-1:0] rd_addr1, wr_addr1;
  logic [DW-1:0] wr_data1, dram_rd_data1;
  logic          wr_req1;
  logic          rd_grant1, rd_data_valid1, rd_done1, wr_grant1, wr_beat1, wr_done1;
  logic          fpu_ready1, dram_write1;
  logic [DW-1:0] rd_data1, dram_wr_data1;
  logic [AW-1:0] dram_addr1;

  fpu_dram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(rd_grant), .rd_data(rd_data),
    .rd_data_valid(rd_data_valid), .rd_done(rd_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_grant(wr_grant),
    .wr_beat(wr_beat), .wr_done(wr_done),
    .fpu_ready(fpu_ready), .dram_ready(dram_ready), .dram_write(dram_write),
    .dram_addr(dram_addr), .dram_wr_data(dram_wr_data), .dram_rd_data(dram_rd_data)
  );

  fpu_dram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req1), .rd_addr(rd_addr1), .rd_grant(rd_grant1), .rd_data(rd_data1),
    .rd_data_valid(rd_data_valid1), .rd_done(rd_done1),
    .wr_req(wr_req1), .wr_addr(wr_addr1), .wr_data(wr_data1), .wr_grant(wr_grant1),
    .wr_beat(wr_beat1), .wr_done(wr_done1),
    .fpu_ready(fpu_ready1), .dram_ready(dram_ready1), .dram_write(dram_write1),
    .dram_addr(dram_addr1), .dram_wr_data(dram_wr_data1), .dram_rd_data(dram_rd_data1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks, n_errors;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // owner / done codes: 0 none, 1 read, 2 write
  int            m_owner, m_beats, m_done_owner, m_last;
  logic [AW-1:0] m_base;

  function automatic int pick_owner(input logic r, input logic w, input int last);
    if (r && w) return (last == 2) ? 1 : 2;
    return r ? 1 : 2;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= 0; m_beats <= 0; m_done_owner <= 0; m_last <= 2; m_base <= '0;
    end else if (m_done_owner != 0) begin
      m_last       <= m_done_owner;
      m_done_owner <= 0;
    end else if (m_owner != 0) begin
      if (dram_ready) begin
        if (m_beats == BL - 1) begin
          m_done_owner <= m_owner;
          m_owner      <= 0;
        end else begin
          m_beats <= m_beats + 1;
        end
      end
    end else if (rd_req || wr_req) begin
      m_owner <= pick_owner(rd_req, wr_req, m_last);
      m_base  <= (pick_owner(rd_req, wr_req, m_last) == 1) ? rd_addr : wr_addr;
      m_beats <= 0;
    end
  end

  logic          e_rd_grant, e_wr_grant, e_fpu_ready, e_dram_write, e_rd_valid, e_wr_beat;
  logic          e_rd_done, e_wr_done;
  logic [AW-1:0] e_dram_addr;
  logic [DW-1:0] e_rd_data, e_wr_data;

  always_comb begin
    e_rd_grant   = (m_owner == 1);
    e_wr_grant   = (m_owner == 2);
    e_fpu_ready  = (m_owner != 0);
    e_dram_write = (m_owner == 2);
    e_dram_addr  = (m_owner != 0) ? m_base + AW'(m_beats) * AW'(DW / 8) : '0;
    e_rd_valid   = (m_owner == 1) && dram_ready;
    e_rd_data    = e_rd_valid ? dram_rd_data : '0;
    e_wr_beat    = (m_owner == 2) && dram_ready;
    e_wr_data    = (m_owner == 2) ? wr_data : '0;
    e_rd_done    = (m_done_owner == 1);
    e_wr_done    = (m_done_owner == 2);
  end

  // ---------------- compare and event logging ----------------
  logic [AW-1:0] beat_addr[$];
  int            grant_own[$], grant_cyc[$], done_cyc[$], wr_beat_log[$];
  int            done1_cyc[$], valid1_log[$];
  int            cyc_n;
  logic          prev_rd_g, prev_wr_g, wr_beat_seen, rd_done_seen, wr_done_seen;
  logic [31:0]   wr_tag;
  int            wr_idx;

  initial cyc_n = 0;

  always @(negedge clk) begin
    wr_beat_seen <= wr_beat;
    rd_done_seen <= rd_done;
    wr_done_seen <= wr_done;
    prev_rd_g    <= rd_grant;
    prev_wr_g    <= wr_grant;
    if (rst_n) begin
      cyc_n <= cyc_n + 1;
      chk("rd_grant", 64'(rd_grant), 64'(e_rd_grant));
      chk("wr_grant", 64'(wr_grant), 64'(e_wr_grant));
      chk("grant_overlap", 64'(rd_grant & wr_grant), 64'd0);
      chk("fpu_ready", 64'(fpu_ready), 64'(e_fpu_ready));
      chk("dram_write", 64'(dram_write), 64'(e_dram_write));
      chk("dram_addr", 64'(dram_addr), 64'(e_dram_addr));
      chk("rd_data_valid", 64'(rd_data_valid), 64'(e_rd_valid));
      chk("rd_data", rd_data, e_rd_data);
      chk("wr_beat", 64'(wr_beat), 64'(e_wr_beat));
      chk("dram_wr_data", dram_wr_data, e_wr_data);
      chk("rd_done", 64'(rd_done), 64'(e_rd_done));
      chk("wr_done", 64'(wr_done), 64'(e_wr_done));
      if (fpu_ready && dram_ready) beat_addr.push_back(dram_addr);
      if (wr_beat) begin
        wr_beat_log.push_back(cyc_n);
        // requester numbers its beats 0..BL-1 within a burst
        chk("wr_beat_order", dram_wr_data, {wr_tag, 32'(m_beats)});
      end
      if (rd_grant && !prev_rd_g) begin grant_own.push_back(1); grant_cyc.push_back(cyc_n); end
      if (wr_grant && !prev_wr_g) begin grant_own.push_back(2); grant_cyc.push_back(cyc_n); end
      if (rd_done || wr_done) done_cyc.push_back(cyc_n);
      // single-beat instance: read-only traffic at a fixed base address
      chk("bl1_wr_grant", 64'({wr_grant1, wr_beat1, wr_done1, dram_write1}), 64'd0);
      chk("bl1_wr_data", dram_wr_data1, 64'd0);
      chk("bl1_ready", 64'(fpu_ready1), 64'(rd_grant1));
      chk("bl1_valid", 64'(rd_data_valid1), 64'(rd_grant1 && dram_ready1));
      chk("bl1_addr", 64'(dram_addr1), rd_grant1 ? 64'h500 : 64'd0);
      if (rd_data_valid1) begin
        chk("bl1_rd_data", rd_data1, dram_rd_data1);
        valid1_log.push_back(cyc_n);
      end
      if (rd_done1) done1_cyc.push_back(cyc_n);
    end
  end

  // ---------------- requester / DRAM driver ----------------
  logic hold_reqs, rand_reqs, rand_ready;
  int   stall_left;

  task automatic step();
    @(posedge clk);
    #1;
    if (wr_beat_seen) wr_idx++;
    if (wr_done_seen) begin
      wr_idx = 0;
      if (!hold_reqs) wr_req = 1'b0;
    end
    if (rd_done_seen && !hold_reqs) rd_req = 1'b0;
    if (rand_reqs) begin
      if (!rd_req && $urandom_range(0, 3) == 0) begin
        rd_req  = 1'b1;
        rd_addr = $urandom;
      end
      if (!wr_req && $urandom_range(0, 3) == 0) begin
        wr_req  = 1'b1;
        wr_addr = $urandom;
        wr_tag  = $urandom;
        wr_idx  = 0;
      end
    end
    wr_data       = {wr_tag, 32'(wr_idx)};
    dram_rd_data  = {$urandom, $urandom};
    dram_rd_data1 = {$urandom, $urandom};
    if (rand_ready) begin
      if (stall_left > 0) begin
        dram_ready = 1'b0;
        stall_left--;
      end else begin
        dram_ready = 1'b1;
        if ($urandom_range(0, 2) == 0) stall_left = $urandom_range(0, 10);
      end
    end else begin
      dram_ready = 1'b1;
    end
  endtask

  task automatic clear_logs();
    beat_addr.delete(); grant_own.delete(); grant_cyc.delete();
    done_cyc.delete(); wr_beat_log.delete();
  endtask

  task automatic wait_dones(input int target, input int bound, input string name);
    int n = 0;
    while (done_cyc.size() < target && n < bound) begin
      step();
      n++;
    end
    chk(name, 64'(done_cyc.size() >= target), 64'd1);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while ((m_owner != 0 || m_done_owner != 0 || rd_req || wr_req) && n < bound) begin
      step();
      n++;
    end
    chk("idle_timeout", 64'(n < bound), 64'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    hold_reqs = 1'b0; rand_reqs = 1'b0; rand_ready = 1'b0; stall_left = 0;
    wr_tag = 32'hC0DE_0000; wr_idx = 0;
    rst_n = 1'b0;
    rd_req = 1'b1; wr_req = 1'b1; rd_addr = 32'h1234; wr_addr = 32'h5678;
    wr_data = '1; dram_rd_data = '1; dram_ready = 1'b1;
    rd_req1 = 1'b0; rd_addr1 = 32'h500; wr_req1 = 1'b0; wr_addr1 = '0; wr_data1 = '1;
    dram_rd_data1 = '1; dram_ready1 = 1'b1;

    // Reset: every output low despite active inputs
    #12;
    chk("rst_grants", 64'({rd_grant, wr_grant, fpu_ready, dram_write}), 64'd0);
    chk("rst_strobes", 64'({rd_data_valid, wr_beat, rd_done, wr_done}), 64'd0);
    chk("rst_dram_addr", 64'(dram_addr), 64'd0);
    chk("rst_dram_wr_data", dram_wr_data, 64'd0);
    chk("rst_rd_data", rd_data, 64'd0);
    rd_req = 1'b0; wr_req = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) step();

    // Single read burst at 0x1000, no stalls
    clear_logs();
    rd_addr = 32'h1000; rd_req = 1'b1;
    wait_dones(1, 40, "single_read_timeout");
    chk("single_read_beats", 64'(beat_addr.size()), 64'd8);
    for (int i = 0; i < 8; i++) chk("single_read_addr", 64'(beat_addr[i]), 64'(32'h1000 + 8 * i));
    chk("single_read_done_lat", 64'(done_cyc[0] - grant_cyc[0]), 64'd8);
    repeat (3) step();

    // Both requesting from reset, held: read, write, read, write
    do_reset();
    clear_logs();
    hold_reqs = 1'b1; wr_idx = 0; wr_tag = 32'h0BAD_F00D;
    rd_addr = 32'h100; wr_addr = 32'h800; rd_req = 1'b1; wr_req = 1'b1;
    begin
      int n = 0;
      while (grant_own.size() < 4 && n < 80) begin step(); n++; end
    end
    chk("rr_grant_count", 64'(grant_own.size() >= 4), 64'd1);
    if (grant_own.size() >= 4) begin
      chk("rr_order0", 64'(grant_own[0]), 64'd1);
      chk("rr_order1", 64'(grant_own[1]), 64'd2);
      chk("rr_order2", 64'(grant_own[2]), 64'd1);
      chk("rr_order3", 64'(grant_own[3]), 64'd2);
      for (int i = 1; i < 4; i++) begin
        chk("rr_period", 64'(grant_cyc[i] - grant_cyc[i-1]), 64'(BL + 2));
        chk("rr_bubble", 64'(grant_cyc[i] - done_cyc[i-1]), 64'd2);
      end
    end
    rd_req = 1'b0; wr_req = 1'b0; hold_reqs = 1'b0;
    wait_idle(100);

    // Write burst with random stalls
    clear_logs();
    rand_ready = 1'b1; wr_tag = 32'h5EED_0001; wr_idx = 0; wr_data = {wr_tag, 32'd0};
    wr_addr = 32'h2000; wr_req = 1'b1;
    wait_dones(1, 300, "stall_write_timeout");
    chk("stall_write_beats", 64'(wr_beat_log.size()), 64'd8);
    for (int i = 0; i < 8; i++) chk("stall_write_addr", 64'(beat_addr[i]), 64'(32'h2000 + 8 * i));
    rand_ready = 1'b0;
    wait_idle(50);

    // Address wrap with the write request dropped mid-burst
    clear_logs();
    wr_tag = 32'h0000_FFFF; wr_idx = 0; wr_data = {wr_tag, 32'd0};
    wr_addr = 32'hFFFF_FFF8; wr_req = 1'b1;
    begin
      int n = 0;
      while (wr_beat_log.size() < 3 && n < 40) begin step(); n++; end
    end
    wr_req = 1'b0;
    wait_dones(1, 40, "wrap_timeout");
    chk("wrap_beats", 64'(beat_addr.size()), 64'd8);
    chk("wrap_addr0", 64'(beat_addr[0]), 64'hFFFF_FFF8);
    chk("wrap_addr1", 64'(beat_addr[1]), 64'h0);
    chk("wrap_addr7", 64'(beat_addr[7]), 64'h30);
    wait_idle(50);

    // Reset during beat 3 of a read burst
    clear_logs();
    rd_addr = 32'h3000; rd_req = 1'b1;
    begin
      int n = 0;
      while (beat_addr.size() < 3 && n < 40) begin step(); n++; end
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_grants", 64'({rd_grant, wr_grant, fpu_ready, dram_write}), 64'd0);
    chk("midrst_strobes", 64'({rd_data_valid, wr_beat, rd_done, wr_done}), 64'd0);
    chk("midrst_dram_addr", 64'(dram_addr), 64'd0);
    chk("midrst_rd_data", rd_data, 64'd0);
    clear_logs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rd_addr = 32'h4000;
    wait_dones(1, 40, "postrst_timeout");
    chk("postrst_beats", 64'(beat_addr.size()), 64'd8);
    chk("postrst_addr0", 64'(beat_addr[0]), 64'h4000);
    chk("postrst_addr7", 64'(beat_addr[7]), 64'h4038);
    wait_idle(50);

    // Random traffic on both channels with random stalls
    rand_ready = 1'b1; rand_reqs = 1'b1;
    repeat (1500) step();
    rand_reqs = 1'b0;
    wait_idle(400);
    rand_ready = 1'b0;

    // Single-beat configuration, read request held
    rd_req1 = 1'b1;
    repeat (20) step();
    rd_req1 = 1'b0;
    repeat (5) step();
    chk("bl1_burst_count", 64'(done1_cyc.size() >= 5), 64'd1);
    if (done1_cyc.size() >= 5 && valid1_log.size() >= 5) begin
      for (int i = 1; i < 5; i++) chk("bl1_spacing", 64'(done1_cyc[i] - done1_cyc[i-1]), 64'd3);
      for (int i = 0; i < 5; i++) chk("bl1_beat_to_done", 64'(done1_cyc[i] - valid1_log[i]), 64'd1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
